// File: rtl/register_file_mp_if.sv
// Bus bundle between the core (master) and the multi-port register file (slave).
// Read and write ports are packed: port i sits at [i*W +: W].
interface register_file_mp_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] wa;
  logic [NUM_WR*DATA_W-1:0] wd;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic                     ready;
  logic                     wr_conflict;

  modport master (output we, wa, wd, ra, input rd, ready, wr_conflict);
  modport slave  (input we, wa, wd, ra, output rd, ready, wr_conflict);
endinterface

// File: rtl/register_file_mp.sv
// Multi-port integer register file with same-cycle write bypass, prioritised
// write ports, optional hard-wired zero register and a post-reset clear sweep.
//
// state | meaning
// CLEAR | sweeping rf[0..DEPTH-1] to zero, writes ignored, reads return 0
// RUN   | normal operation, ready=1
module register_file_mp #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input logic               clk,
  input logic               rst_n,
  register_file_mp_if.slave bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                conflict_q, conflict_d;
  logic [DATA_W-1:0]   rf_q [DEPTH];
  logic [ADDR_W-1:0]   wa_w [NUM_WR];
  logic [DATA_W-1:0]   wd_w [NUM_WR];
  logic [NUM_RD*DATA_W-1:0] rd_d;

  // Writable and readable addresses are the same set.
  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      wa_w[i] = bus.wa[i*ADDR_W +: ADDR_W];
      wd_w[i] = bus.wd[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    conflict_d = 1'b0;
    case (state_q)
      CLEAR: begin
        cnt_d   = cnt_q + 1'b1;
        ready_d = 1'b0;
        if (cnt_q == LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        ready_d = 1'b1;
        for (int i = 0; i < NUM_WR; i++) begin
          for (int j = i + 1; j < NUM_WR; j++) begin
            if (bus.we[i] && bus.we[j] && (wa_w[i] == wa_w[j]) && writable(wa_w[i]))
              conflict_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // Array has no reset; the clear sweep zeroes it. Ascending port order makes
  // the highest-index port win a collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        rf_q[cnt_q] <= '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (bus.we[i] && writable(wa_w[i]))
            rf_q[wa_w[i]] <= wd_w[i];
        end
      end
    end
  end

  always_comb begin
    rd_d = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      a = bus.ra[r*ADDR_W +: ADDR_W];
      v = '0;
      if ((state_q == RUN) && writable(a)) begin
        v = rf_q[a];
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.we[w] && (wa_w[w] == a))
            v = wd_w[w];
        end
      end
      rd_d[r*DATA_W +: DATA_W] = v;
    end
  end

  assign bus.rd          = rd_d;
  assign bus.ready       = ready_q;
  assign bus.wr_conflict = conflict_q;

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file for the pipelined core, replacing the fixed 2-read/1-write array. It provides NUM_RD combinational read ports with same-cycle write-to-read bypass, NUM_WR prioritised write ports, a configurable hard-wired zero register, and a post-reset clear sequencer that zeroes the whole array before the core may use it. It sits between decode (read ports) and writeback (write ports).

## Interface
- ADDR_W, 5, register address width
- DATA_W, 32, register data width
- DEPTH, 32, number of registers; DEPTH <= 2**ADDR_W
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous, active-low reset
- we  input  NUM_WR  per-port write enable
- wa  input  NUM_WR*ADDR_W  write addresses, port i at [i*ADDR_W +: ADDR_W]
- wd  input  NUM_WR*DATA_W  write data, port i at [i*DATA_W +: DATA_W]
- ra  input  NUM_RD*ADDR_W  read addresses, packed as wa
- rd  output  NUM_RD*DATA_W  read data, packed as wd
- ready  output  1  array cleared and accepting writes
- wr_conflict  output  1  registered pulse: two or more enabled write ports hit the same writable address last cycle

## Operation
- State machine, two states: CLEAR, RUN.
- rst_n low at a rising edge: state <= CLEAR, clear counter <= 0, ready <= 0, wr_conflict <= 0. Array contents are not touched by reset itself.
- CLEAR (rst_n high): each cycle write 0 to rf[cnt], cnt <= cnt+1; after writing rf[DEPTH-1], state <= RUN and ready <= 1. The clear takes exactly DEPTH cycles.
- In CLEAR, we is ignored, every rd port returns 0, and wr_conflict stays 0.
- RUN: for each port i with we[i]=1 and a writable wa[i], rf[wa[i]] <= wd[i].
- Writable address: wa < DEPTH, and not 0 when ZERO_REG=1. Non-writable writes are dropped silently.
- Write collision (RUN only): when multiple enabled ports target the same writable address, the highest port index wins, and wr_conflict is 1 on the following cycle for one cycle.
- Reads (RUN, combinational): if ra is not readable (ra >= DEPTH, or ra = 0 with ZERO_REG=1), rd = 0.
- Otherwise, if any enabled write port targets ra this cycle, rd = wd of the highest-index such port (bypass). Else rd = rf[ra].
- Bypass never applies to non-writable addresses.
- Reset asserted mid-RUN: next edge enters CLEAR, ready drops, and the full DEPTH-cycle clear repeats. Any write presented on that edge is dropped.

## Timing
- Reset values: ready=0, wr_conflict=0, rd=0 (CLEAR state), state=CLEAR, cnt=0.
- ready rises on the edge that writes rf[DEPTH-1], i.e. DEPTH rising edges after the first edge with rst_n high.
- Read latency 0: rd follows ra/we/wa/wd combinationally within the cycle.
- Write latency 1: a value is in the array after the rising edge and is visible via bypass in the same cycle.
- wr_conflict: asserted for exactly one cycle, the cycle after the colliding edge. It deasserts unless a new collision occurs.
- No stalls or back-pressure. Writes in RUN always complete in one cycle.

## Test plan
- Reset clear: preload rf[5]=0xDEAD via writes, assert rst_n low 1 cycle, release. Required: ready=0 for 32 cycles, then 1; rd(ra=5)=0 throughout and after; a write presented during CLEAR is dropped.
- Basic R/W with bypass: RUN, port0 writes 0x1234 to r7 while ra0=7. Required: rd0=0x1234 in the same cycle; rd0 still 0x1234 the next cycle with we=0.
- Zero register: ZERO_REG=1, write 0xFFFF_FFFF to r0 on both ports. Required: rd(ra=0)=0 in the same and next cycle; wr_conflict stays 0.
- Collision priority: port0 writes 0xAAAA and port1 writes 0xBBBB to r3 in the same cycle. Required: bypass rd(ra=3)=0xBBBB, array r3=0xBBBB next cycle, wr_conflict=1 for exactly one cycle.
- Out-of-range address: DEPTH=24, ADDR_W=5, write 0x55 to address 30. Required: dropped; rd(ra=30)=0 with no bypass; no existing register changes.
- Reset mid-operation: in RUN with r9=0x4, pulse rst_n low. Required: ready falls on that edge; after 32 clear cycles rd(ra=9)=0 and ready=1.
